// File: rtl/bnn_xnor_pe_array_if.sv
// Handshake and data bundle for the XNOR-popcount PE array.
// The master drives beats and result-ready; the slave (the PE) drives everything else.
interface bnn_xnor_pe_array_if #(
  parameter int unsigned WORD_SIZE = 64,
  parameter int unsigned LANES     = 4,
  parameter int unsigned ACC_W     = 16
);
  logic                       in_valid;
  logic                       in_ready;
  logic                       in_first;
  logic                       in_last;
  logic [WORD_SIZE-1:0]       activation_in;
  logic [WORD_SIZE-1:0]       mask_in;
  logic [LANES*WORD_SIZE-1:0] weight_in;
  logic [WORD_SIZE-1:0]       act_out;
  logic                       act_out_valid;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES*ACC_W-1:0]     out_sum;
  logic [LANES-1:0]           out_ovf;
  logic [LANES*ACC_W-1:0]     thresh_in;
  logic [LANES-1:0]           out_bit;

  modport master (
    output in_valid, in_first, in_last, activation_in, mask_in, weight_in,
    output out_ready, thresh_in,
    input  in_ready, act_out, act_out_valid, out_valid, out_sum, out_ovf, out_bit
  );

  modport slave (
    input  in_valid, in_first, in_last, activation_in, mask_in, weight_in,
    input  out_ready, thresh_in,
    output in_ready, act_out, act_out_valid, out_valid, out_sum, out_ovf, out_bit
  );
endinterface

// File: rtl/bnn_xnor_pe_array.sv
// Multi-lane XNOR-popcount PE: framed, saturating per-lane dot products with a systolic activation tap.
// Optional threshold binarisation of the result is enabled by defining BNN_PE_THRESHOLD_EN.
module bnn_xnor_pe_array #(
  parameter int unsigned WORD_SIZE = 64,
  parameter int unsigned LANES     = 4,
  parameter int unsigned ACC_W     = 16
) (
  input logic                clk,
  input logic                reset,
  bnn_xnor_pe_array_if.slave bus
);
  localparam int unsigned PCW  = $clog2(WORD_SIZE + 1);
  localparam int unsigned SUMW = ACC_W + 1;

  function automatic logic [PCW-1:0] popcount(input logic [WORD_SIZE-1:0] v);
    logic [PCW-1:0] c;
    c = '0;
    for (int unsigned b = 0; b < WORD_SIZE; b++) c = c + PCW'(v[b]);
    return c;
  endfunction

  logic                       stall_c;
  logic                       accept_c;
  logic                       s2_fire_c;
  logic [LANES-1:0][PCW-1:0]  pc_d;
  logic [LANES-1:0][SUMW-1:0] wide_c;
  logic [LANES-1:0][ACC_W-1:0] sum_c;
  logic [LANES-1:0]           ovf_c;

  logic                        s1_valid_q;
  logic                        first_q;
  logic                        last_q;
  logic [LANES-1:0][PCW-1:0]   pc_q;
  logic [LANES-1:0][ACC_W-1:0] acc_q;
  logic [LANES-1:0]            ovf_q;
  logic [WORD_SIZE-1:0]        act_out_q;
  logic                        act_out_valid_q;
  logic                        out_valid_q;
  logic [LANES-1:0][ACC_W-1:0] out_sum_q;
  logic [LANES-1:0]            out_ovf_q;

  // A held result freezes the whole pipeline so no beat is dropped.
  assign stall_c   = out_valid_q & ~bus.out_ready;
  assign accept_c  = bus.in_valid & ~stall_c;
  assign s2_fire_c = s1_valid_q & ~stall_c;

  assign bus.in_ready      = ~stall_c;
  assign bus.act_out       = act_out_q;
  assign bus.act_out_valid = act_out_valid_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_sum       = out_sum_q;
  assign bus.out_ovf       = out_ovf_q;

  always_comb begin
    pc_d = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      pc_d[i] = popcount(~(bus.weight_in[i*WORD_SIZE +: WORD_SIZE] ^ bus.activation_in)
                         & bus.mask_in);
    end
  end

  // A first beat restarts the lane from zero, discarding any open partial sum.
  always_comb begin
    wide_c = '0;
    sum_c  = '0;
    ovf_c  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      wide_c[i] = SUMW'(first_q ? '0 : acc_q[i]) + SUMW'(pc_q[i]);
      sum_c[i]  = wide_c[i][ACC_W] ? '1 : wide_c[i][ACC_W-1:0];
      ovf_c[i]  = (~first_q & ovf_q[i]) | wide_c[i][ACC_W];
    end
  end

`ifdef BNN_PE_THRESHOLD_EN
  logic [LANES-1:0] thr_c;
  logic [LANES-1:0] out_bit_q;

  always_comb begin
    thr_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      thr_c[i] = sum_c[i] >= bus.thresh_in[i*ACC_W +: ACC_W];
    end
  end

  assign bus.out_bit = out_bit_q;
`else
  logic unused_thresh;
  assign unused_thresh = ^bus.thresh_in;
  assign bus.out_bit   = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q      <= 1'b0;
      first_q         <= 1'b0;
      last_q          <= 1'b0;
      pc_q            <= '0;
      acc_q           <= '0;
      ovf_q           <= '0;
      act_out_q       <= '0;
      act_out_valid_q <= 1'b0;
      out_valid_q     <= 1'b0;
      out_sum_q       <= '0;
      out_ovf_q       <= '0;
`ifdef BNN_PE_THRESHOLD_EN
      out_bit_q       <= '0;
`endif
    end else begin
      act_out_valid_q <= accept_c;
      if (accept_c) act_out_q <= bus.activation_in;

      if (!stall_c) begin
        s1_valid_q <= accept_c;
        if (accept_c) begin
          first_q <= bus.in_first;
          last_q  <= bus.in_last;
          pc_q    <= pc_d;
        end
      end

      if (s2_fire_c) begin
        if (last_q) begin
          acc_q <= '0;
          ovf_q <= '0;
        end else begin
          acc_q <= sum_c;
          ovf_q <= ovf_c;
        end
      end

      // Loading a new result takes priority over retiring the old one (no bubble).
      if (s2_fire_c && last_q) begin
        out_valid_q <= 1'b1;
        out_sum_q   <= sum_c;
        out_ovf_q   <= ovf_c;
`ifdef BNN_PE_THRESHOLD_EN
        out_bit_q   <= thr_c;
`endif
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_sum_q   <= '0;
        out_ovf_q   <= '0;
`ifdef BNN_PE_THRESHOLD_EN
        out_bit_q   <= '0;
`endif
      end
    end
  end
endmodule
